// File: rtl/wb_mem_drain_pkg.sv
// ============================================================================
// Module   : wb_mem_drain_pkg
// Purpose  : Shared widths, state encoding and helpers for the write-buffer
//            drain engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_mem_drain_pkg;

  localparam int ADDR_W     = 27;
  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int CNT_W      = 16;
  localparam int MEM_ADDR_W = 32;

  function automatic int byte_off_w(input int beat_bits);
    return $clog2(beat_bits / 8);
  endfunction

  localparam int BYTE_OFF_W = byte_off_w(BEAT_W);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_mem_drain_if.sv
// ============================================================================
// Module   : wb_mem_drain_if
// Purpose  : Buffer-head pop handshake plus memory write beat bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_mem_drain_if;
  import wb_mem_drain_pkg::*;

  logic                  entry_valid;
  logic [ADDR_W-1:0]     entry_addr;
  logic [LINE_W-1:0]     entry_data;
  logic                  entry_pop;
  logic                  mem_valid;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0]     mem_wdata;
  logic                  mem_last;
  logic                  mem_ready;

  // master: the drain engine, which masters the memory write bus
  modport master (
    input  entry_valid, entry_addr, entry_data, mem_ready,
    output entry_pop, mem_valid, mem_addr, mem_wdata, mem_last
  );

  modport slave (
    output entry_valid, entry_addr, entry_data, mem_ready,
    input  entry_pop, mem_valid, mem_addr, mem_wdata, mem_last
  );

endinterface

`default_nettype wire

// File: rtl/wb_beat_mux.sv
// ============================================================================
// Module   : wb_beat_mux
// Purpose  : Selects one BEAT_W slice of a cache line, beat 0 = low bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_beat_mux
  import wb_mem_drain_pkg::*;
(
  input  wire logic [LINE_W-1:0]     line_i,
  input  wire logic [BEAT_IDX_W-1:0] beat_i,
  output logic      [BEAT_W-1:0]     beat_o
);

  logic [BEAT_W-1:0] w_slices [BEATS];

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign w_slices[gi] = line_i[gi*BEAT_W +: BEAT_W];
  end

  assign beat_o = w_slices[beat_i];

endmodule

`default_nettype wire

// File: rtl/wb_mem_drain.sv
// ============================================================================
// Module   : wb_mem_drain
// Purpose  : Pops one write-buffer line and serialises it into eight memory
//            write beats with per-beat ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem_drain
  import wb_mem_drain_pkg::*;
(
  input  wire logic        clock_i,
  input  wire logic        reset_i,
  wb_mem_drain_if.master   bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] lines_written_o
);

  state_t                  state_q, state_d;
  logic [BEAT_IDX_W-1:0]   beat_q,  beat_d;
  logic [ADDR_W-1:0]       addr_q,  addr_d;
  logic [LINE_W-1:0]       data_q,  data_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;

  logic                    w_pop;
  logic                    w_valid;
  logic                    w_last;
  logic [MEM_ADDR_W-1:0]   w_addr;
  logic [BEAT_W-1:0]       w_wdata;
  logic [BEAT_W-1:0]       w_slice;

  wb_beat_mux u_beat_mux (
    .line_i (data_q),
    .beat_i (beat_q),
    .beat_o (w_slice)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    w_pop   = 1'b0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_addr  = '0;
    w_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        // Reset gates the pop so an entry is never consumed while being cleared
        w_pop = bus.entry_valid && !reset_i;
        if (w_pop) begin
          addr_d  = bus.entry_addr;
          data_d  = bus.entry_data;
          beat_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        w_valid = 1'b1;
        w_last  = (beat_q == LAST_BEAT);
        w_addr  = {addr_q, beat_q, {BYTE_OFF_W{1'b0}}};
        w_wdata = w_slice;
        if (bus.mem_ready) begin
          if (w_last) begin
            cnt_d   = cnt_q + 1'b1;
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.entry_pop   = w_pop;
  assign bus.mem_valid   = w_valid;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_wdata   = w_wdata;
  assign bus.mem_last    = w_last;
  assign busy_o          = (state_q == ST_SEND);
  assign lines_written_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_drain.sv
// ============================================================================
// Module   : tb_wb_mem_drain
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            a randomized run against a line-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mem_drain;
  import wb_mem_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] lines;

  always #5 clk = ~clk;

  wb_mem_drain_if bus();

  wb_mem_drain dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .bus             (bus),
    .busy_o          (busy),
    .lines_written_o (lines)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic         d_rst, d_ev, d_rdy;
  logic [26:0]  d_addr;
  logic [255:0] d_data;

  logic         s_pop, s_valid, s_last, s_busy;
  logic [31:0]  s_addr, s_wdata;
  logic [15:0]  s_lines;
  int           cyc = 0;

  typedef struct {
    logic        ev;
    logic        rdy;
    logic        e_pop;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_last;
    logic        e_busy;
    logic [15:0] e_lines;
  } vec_t;

  typedef struct packed {
    logic [26:0]  a;
    logic [255:0] d;
  } entry_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        last;
  } beat_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  // Drive the current stimulus just after the falling edge and sample the
  // combinational response well before the next rising edge.
  task automatic step();
    @(negedge clk);
    rst             = d_rst;
    bus.entry_valid = d_ev;
    bus.entry_addr  = d_addr;
    bus.entry_data  = d_data;
    bus.mem_ready   = d_rdy;
    #1;
    s_pop   = bus.entry_pop;
    s_valid = bus.mem_valid;
    s_addr  = bus.mem_addr;
    s_wdata = bus.mem_wdata;
    s_last  = bus.mem_last;
    s_busy  = busy;
    s_lines = lines;
    cyc++;
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_ev = 1'b0; d_rdy = 1'b0;
    step();
    step();
    d_rst = 1'b0;
  endtask

  vec_t   tbl [10];
  entry_t up_q [$];
  beat_t  exp_q [$];

  initial begin
    int     n, acc, npop, pop1, pop2, held, sendc, popbusy, lines_model;
    logic   first2, prev_stall;
    beat_t  eb, prev;
    entry_t en;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0};
    for (int k = 0; k < 8; k++)
      tbl[k+1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2460 + 32'(4*k),
                   32'hA000_0000 + 32'(k), (k == 7), 1'b1, 16'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd1};

    // Reset hold with an entry offered
    d_rst = 1'b1; d_ev = 1'b1; d_rdy = 1'b1;
    d_addr = 27'h0000123; d_data = mk_line(32'hA000_0000);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pop",   s_pop,   0);
      check("rst_valid", s_valid, 0);
      check("rst_lines", s_lines, 0);
    end
    d_rst = 1'b0;

    // Single line, no stall: table-driven
    for (int i = 0; i < 10; i++) begin
      d_ev = tbl[i].ev; d_rdy = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d_pop", i),   s_pop,   tbl[i].e_pop);
      check($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_addr", i),  s_addr,  tbl[i].e_addr);
      check($sformatf("tbl%0d_wdata", i), s_wdata, tbl[i].e_wdata);
      check($sformatf("tbl%0d_last", i),  s_last,  tbl[i].e_last);
      check($sformatf("tbl%0d_busy", i),  s_busy,  tbl[i].e_busy);
      check($sformatf("tbl%0d_lines", i), s_lines, tbl[i].e_lines);
    end

    // Backpressure: ready low for 3 cycles while beat 2 is presented
    do_reset();
    d_ev = 1'b1; d_rdy = 1'b1;
    step();
    check("bp_pop", s_pop, 1);
    d_ev = 1'b0;
    n = 0; acc = 0; held = 0; sendc = 0;
    for (int i = 0; i < 40; i++) begin
      n++;
      d_rdy = !(n >= 3 && n <= 5);
      step();
      if (s_valid) begin
        sendc++;
        if (s_addr == 32'h0000_2468) held++;
        if (d_rdy) begin
          check("bp_addr",  s_addr,  32'h0000_2460 + 32'(4*acc));
          check("bp_wdata", s_wdata, 32'hA000_0000 + 32'(acc));
          check("bp_last",  s_last,  acc == 7);
          acc++;
        end
      end else break;
    end
    check("bp_send_cycles", sendc, 11);
    check("bp_beat2_held",  held,  4);
    check("bp_beats",       acc,   8);
    check("bp_lines",       s_lines, 1);

    // Back-to-back: entry_valid held high through SEND
    do_reset();
    d_ev = 1'b1; d_rdy = 1'b1; d_addr = 27'h1; d_data = mk_line(32'h1111_0000);
    npop = 0; pop1 = 0; pop2 = 0; popbusy = 0; first2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_pop && s_busy) popbusy++;
      if (first2 && s_valid) begin
        check("b2b_second_addr", s_addr, 32'h0000_0040);
        first2 = 1'b0;
      end
      if (s_pop) begin
        npop++;
        if (npop == 1) begin
          pop1 = cyc; d_addr = 27'h2; d_data = mk_line(32'h2222_0000);
        end else begin
          pop2 = cyc; d_ev = 1'b0; first2 = 1'b1;
        end
      end
      if (npop >= 2 && !s_valid && !s_pop && s_lines == 16'd2) break;
    end
    check("b2b_pops",     npop,        2);
    check("b2b_spacing",  pop2 - pop1, 9);
    check("b2b_pop_busy", popbusy,     0);
    check("b2b_lines",    s_lines,     2);

    // Reset after beat 4 is accepted
    do_reset();
    d_ev = 1'b1; d_rdy = 1'b1; d_addr = 27'h00000AB; d_data = mk_line(32'h5000_0000);
    acc = 0;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      step();
      if (s_pop) d_ev = 1'b0;
      if (s_valid && d_rdy) acc++;
    end
    check("mid_accepted", acc, 5);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check("mid_valid", s_valid, 0);
    check("mid_busy",  s_busy,  0);
    check("mid_addr",  s_addr,  0);
    check("mid_lines", s_lines, 0);
    d_ev = 1'b1; d_addr = 27'h0000055; d_data = mk_line(32'hB000_0000);
    step();
    check("mid_repop", s_pop, 1);
    d_ev = 1'b0;
    step();
    check("mid_beat0_addr",  s_addr,  32'h0000_0AA0);
    check("mid_beat0_wdata", s_wdata, 32'hB000_0000);

    // Randomized run against a line-level model
    do_reset();
    for (int i = 0; i < 20; i++) begin
      en.a = 27'($urandom);
      for (int k = 0; k < 8; k++) en.d[k*32 +: 32] = $urandom;
      up_q.push_back(en);
    end
    lines_model = 0; prev_stall = 1'b0; prev = '0;
    for (int i = 0; i < 3000 && (up_q.size() != 0 || exp_q.size() != 0); i++) begin
      d_ev = (up_q.size() != 0) && ($urandom_range(3) != 0);
      if (d_ev) begin
        d_addr = up_q[0].a; d_data = up_q[0].d;
      end else begin
        d_addr = 27'($urandom); d_data = {8{$urandom}};
      end
      d_rdy = ($urandom_range(9) < 7);
      step();
      check("rnd_valid", s_valid, exp_q.size() != 0);
      check("rnd_busy",  s_busy,  s_valid);
      check("rnd_lines", s_lines, 16'(lines_model));
      check("rnd_pop",   s_pop,   d_ev && exp_q.size() == 0);
      if (prev_stall) begin
        check("rnd_hold_addr",  s_addr,  prev.a);
        check("rnd_hold_wdata", s_wdata, prev.d);
        check("rnd_hold_last",  s_last,  prev.last);
      end
      if (!s_valid) begin
        check("rnd_idle_addr",  s_addr,  0);
        check("rnd_idle_wdata", s_wdata, 0);
        check("rnd_idle_last",  s_last,  0);
      end
      if (s_valid && d_rdy && exp_q.size() != 0) begin
        eb = exp_q.pop_front();
        check("rnd_addr",  s_addr,  eb.a);
        check("rnd_wdata", s_wdata, eb.d);
        check("rnd_last",  s_last,  eb.last);
        if (eb.last) lines_model++;
      end
      if (s_pop && up_q.size() != 0) begin
        en = up_q.pop_front();
        for (int k = 0; k < 8; k++) begin
          eb.a    = (32'(en.a) << 5) + 32'(4*k);
          eb.d    = en.d[k*32 +: 32];
          eb.last = (k == 7);
          exp_q.push_back(eb);
        end
      end
      prev_stall = s_valid && !d_rdy;
      prev.a = s_addr; prev.d = s_wdata; prev.last = s_last;
    end
    check("rnd_drained", up_q.size() + exp_q.size(), 0);
    d_ev = 1'b0;
    step();
    check("rnd_final_lines", s_lines, 16'(lines_model));
    check("rnd_total_lines", lines_model, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
